// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single dmem port between the CPU (requester 0)
// and the read-only VGA board/snake fetcher (requester 1). One access per cycle,
// read data returned to its owner through a tagged RD_LAT-deep pipeline, and
// VGA starvation bounded by STARVE_MAX.
// Optional feature macro: DMEM_ARB_RR_EN. When defined, the default policy is
// round-robin. When undefined, the CPU has fixed priority.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wren,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q,
  output logic [7:0]        starve_peak
);

  typedef enum logic {OWN_CPU = 1'b0, OWN_VGA = 1'b1} owner_e;

  localparam logic [15:0] SMAX = 16'(STARVE_MAX);

  logic              lock_q, lock_d;
  logic [15:0]       starve_cnt_q, starve_cnt_d;
  logic [7:0]        starve_peak_q, starve_peak_d;
  logic [7:0]        cnt_sat8;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  owner_e            rd_own_q [RD_LAT];
  owner_e            rd_own_d [RD_LAT];
`ifdef DMEM_ARB_RR_EN
  owner_e            rr_ptr_q, rr_ptr_d;
`endif

  // Winner selection: forced VGA win beats a CPU lock, lock beats default policy
  always_comb begin
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    if (!reset) begin
      if (vga_req && (starve_cnt_q == SMAX)) begin
        vga_gnt = 1'b1;
      end else if (lock_q && cpu_req) begin
        cpu_gnt = 1'b1;
      end else begin
`ifdef DMEM_ARB_RR_EN
        if (cpu_req && vga_req) begin
          if (rr_ptr_q == OWN_VGA) vga_gnt = 1'b1;
          else                     cpu_gnt = 1'b1;
        end else begin
          cpu_gnt = cpu_req;
          vga_gnt = vga_req;
        end
`else
        if (cpu_req)      cpu_gnt = 1'b1;
        else if (vga_req) vga_gnt = 1'b1;
`endif
      end
    end
  end

  // Next-state for lock, starvation tracking, held port values and return pipeline
  always_comb begin
    lock_d = cpu_gnt & cpu_lock;

    starve_cnt_d = '0;
    if (vga_req && !vga_gnt) begin
      starve_cnt_d = (starve_cnt_q == SMAX) ? SMAX : starve_cnt_q + 16'd1;
    end

    cnt_sat8 = (starve_cnt_q > 16'd255) ? 8'hFF : starve_cnt_q[7:0];
    starve_peak_d = (cnt_sat8 > starve_peak_q) ? cnt_sat8 : starve_peak_q;

    addr_d = addr_q;
    data_d = data_q;
    if (cpu_gnt) begin
      addr_d = cpu_addr;
      data_d = cpu_wdata;
    end else if (vga_gnt) begin
      addr_d = vga_addr;
    end

    rd_vld_d = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) rd_own_d[i] = OWN_CPU;
    rd_vld_d[0] = (cpu_gnt & ~cpu_wren) | vga_gnt;
    rd_own_d[0] = vga_gnt ? OWN_VGA : OWN_CPU;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_own_d[i] = rd_own_q[i-1];
    end

`ifdef DMEM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (cpu_gnt)      rr_ptr_d = OWN_VGA;
    else if (vga_gnt) rr_ptr_d = OWN_CPU;
`endif
  end

  // Output drive; everything reads as zero while reset is asserted so in-flight
  // reads issued before reset never surface
  always_comb begin
    cpu_rvalid   = ~reset & rd_vld_q[RD_LAT-1] & (rd_own_q[RD_LAT-1] == OWN_CPU);
    vga_rvalid   = ~reset & rd_vld_q[RD_LAT-1] & (rd_own_q[RD_LAT-1] == OWN_VGA);
    cpu_rdata    = reset ? '0 : (cpu_rvalid ? dmem_q : cpu_rdata_q);
    vga_rdata    = reset ? '0 : (vga_rvalid ? dmem_q : vga_rdata_q);
    cpu_rdata_d  = cpu_rdata;
    vga_rdata_d  = vga_rdata;
    dmem_address = reset ? '0 : addr_d;
    dmem_data    = reset ? '0 : data_d;
    dmem_wren    = cpu_gnt & cpu_wren;
    starve_peak  = reset ? '0 : starve_peak_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q        <= 1'b0;
      starve_cnt_q  <= '0;
      starve_peak_q <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      cpu_rdata_q   <= '0;
      vga_rdata_q   <= '0;
      rd_vld_q      <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) rd_own_q[i] <= OWN_CPU;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q      <= OWN_CPU;
`endif
    end else begin
      lock_q        <= lock_d;
      starve_cnt_q  <= starve_cnt_d;
      starve_peak_q <= starve_peak_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cpu_rdata_q   <= cpu_rdata_d;
      vga_rdata_q   <= vga_rdata_d;
      rd_vld_q      <= rd_vld_d;
      rd_own_q      <= rd_own_d;
`ifdef DMEM_ARB_RR_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  // Requesters must hold a request until it is granted
  cpu_hold_a: assert property (@(posedge clock) disable iff (reset)
    (cpu_req && !cpu_gnt) |=> cpu_req);
  vga_hold_a: assert property (@(posedge clock) disable iff (reset)
    (vga_req && !vga_gnt) |=> vga_req);
  one_gnt_a: assert property (@(posedge clock) !(cpu_gnt && vga_gnt));

endmodule
